scan_loader: RTL
================

# scan_loader

Upstream driver for the configuration scan chain. Accepts a frame of L words of B bits over a valid/ready handshake and serialises them, MSB first, onto the chain's serial data input. It also generates the chain's scan clock from the system clock as a registered clk/2 waveform, so after one complete frame chain position `q[w][b]` holds bit b of word w. An optional readback path captures the chain's previous contents from the chain's serial output as the new frame shifts in.

## Interface
- `L`, default 8: words per frame; must match chain length; L ≥ 1.
- `B`, default 8: bits per word; must match chain word width; B ≥ 1.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle frame request; honoured only in IDLE.
- `wr_valid`  in  1  host word valid.
- `wr_ready`  out  1  loader can take a word.
- `wr_data`  in  B  word; host sends word L-1 first, word 0 last.
- `scan_clk`  out  1  drives the chain's `clk_scan`; registered.
- `scan_d`  out  1  drives the chain's `d_in`; registered.
- `scan_q`  in  1  chain's `q_out`; used only with readback.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a frame completes.
- `rb_data`  out  B  readback word; present only with readback.
- `rb_valid`  out  1  one-cycle strobe for `rb_data`; present only with readback.

## Operation
- States:
  - IDLE: `start` → WAIT.
  - WAIT: `wr_ready` = 1. Handshake (`wr_valid & wr_ready`) loads a B-bit shift register, clears the bit counter, and moves to LO.
  - LO: `scan_clk` = 0, `scan_d` = current MSB. Next state is HI.
  - HI: `scan_clk` = 1, and the chain captures `scan_d` on this rising edge.
    - If bits remain: shift left, go to LO.
    - Last bit, words remain: go to WAIT.
    - Last bit of word 0: go to DONE.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Counters: `bit_cnt` counts 0..B-1 and `word_cnt` counts 0..L-1. Each is `$clog2` sized, with a minimum width of 1, and wraps to 0 at the start of a frame.
- `wr_ready` is high only in WAIT. `wr_valid` in any other state is ignored; no word is consumed.
- `start` while `busy` is ignored. `start` asserted in the same cycle as DONE is ignored.
- The loader does not stall mid-word. Backpressure exists only between words.
- Bit order: L·B bits total, word L-1 MSB first and word 0 bit 0 last, giving the mapping in the summary.
- Reset values, with rst asserted at any time including mid-frame:
  - state = IDLE
  - `scan_clk` = 0, `scan_d` = 0
  - `wr_ready` = 0, `busy` = 0, `done` = 0
  - `rb_valid` = 0, `rb_data` = 0
  - counters = 0
- Reset mid-frame leaves the chain partially loaded; a fresh frame must be sent afterwards. Because `scan_clk` resets low, reset never creates a spurious rising edge on it.

## Timing
- Handshake at edge E0. For bit k of that word (k = 0 is the MSB):
  - `scan_d` is valid from E(2k) to E(2k+2).
  - `scan_clk` is high from E(2k+1) to E(2k+2).
- Data therefore has one full `clk` period of setup and one of hold around each `scan_clk` rise.
- After a word's last HI, the next edge E(2B) enters WAIT with `wr_ready` = 1. A word presented immediately gives a minimum word period of 2B+1 cycles.
- Frame latency with no backpressure:
  - `start` at edge S; `wr_ready` goes high at S+1.
  - `done` is high during the cycle following E(2B) of word 0.
  - Total is L·(2B+1)+2 cycles from S.
- `busy` falls the cycle after `done`.

## Configuration
- `SCAN_LOADER_READBACK_EN` defined:
  - `scan_q` is sampled at every LO→HI edge, i.e. before the chain shifts, into a B-bit capture register.
  - When the last bit of each word is sampled, `rb_valid` pulses for one cycle with `rb_data` = the complete word.
  - Readback words come out in order L-1 down to 0, MSB first, and hold the chain's contents from before the frame.
  - There is no backpressure on readback.
- Undefined: `scan_q`, `rb_data` and `rb_valid` are absent, and the shift behaviour is identical.

## Test plan
- Basic load (L=2, B=4, connected to a 2×4 chain): send words 0xA then 0x5 → after `done`, `q[1]` = 4'hA and `q[0]` = 4'h5. `scan_d` sequence is 1,0,1,0,0,1,0,1. `done` comes 2·9+2 = 20 cycles after `start`.
- Backpressure: hold `wr_valid` low 5 cycles in each WAIT → `scan_clk` stays low throughout and the final chain contents are unchanged. `wr_valid` pulsed in LO/HI → ignored, no word consumed.
- `start` during busy and `start` coincident with DONE → ignored. Frame count is 1 and `done` pulses exactly once.
- Reset mid-word: assert rst in HI of bit 2 → next cycle `scan_clk` = 0, `busy` = 0, `wr_ready` = 0. A new frame 0x3, 0xC then loads correctly.
- Edge params L=1, B=1: word 1 → one `scan_clk` pulse, `q[0][0]` = 1, `done` 5 cycles after `start`.
- Readback (macro defined): preload the chain with 0xA, 0x5, then load 0x0, 0x0 → `rb_valid` strobes twice with `rb_data` 0xA then 0x5, and the chain ends all-zero.

Source files
------------

// File: rtl/scan_loader.sv
// Scan-chain loader: takes L words of B bits over valid/ready and shifts them MSB first with a
// registered clk/2 scan clock. Optional readback of the old chain contents: SCAN_LOADER_READBACK_EN.
module scan_loader #(
  parameter int L = 8,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [B-1:0] wr_data,
  output logic         scan_clk,
  output logic         scan_d,
`ifdef SCAN_LOADER_READBACK_EN
  input  logic         scan_q,
  output logic [B-1:0] rb_data,
  output logic         rb_valid,
`endif
  output logic         busy,
  output logic         done
);

  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int WW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LO, S_HI, S_DONE} state_t;

  state_t        state, state_next;
  logic [B-1:0]  shreg, shreg_shl;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] word_cnt;
  logic          last_bit, last_word;

  assign shreg_shl = shreg << 1;
  assign last_bit  = (bit_cnt == BW'(B - 1));
  assign last_word = (word_cnt == WW'(L - 1));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_WAIT;
      end
      S_WAIT: begin
        wr_ready = 1'b1;
        if (wr_valid) state_next = S_LO;
      end
      S_LO: state_next = S_HI;
      S_HI: begin
        if (!last_bit)      state_next = S_LO;
        else if (last_word) state_next = S_DONE;
        else                state_next = S_WAIT;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      scan_clk <= 1'b0;
      scan_d   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (start) word_cnt <= '0;
        S_WAIT: begin
          if (wr_valid) begin
            shreg   <= wr_data;
            bit_cnt <= '0;
            scan_d  <= wr_data[B-1];
          end
        end
        S_LO: scan_clk <= 1'b1;
        S_HI: begin
          scan_clk <= 1'b0;
          if (!last_bit) begin
            shreg   <= shreg_shl;
            bit_cnt <= bit_cnt + BW'(1);
            scan_d  <= shreg_shl[B-1];
          end else if (!last_word) begin
            word_cnt <= word_cnt + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCAN_LOADER_READBACK_EN
  logic [B-1:0] cap, cap_next;

  // Sampled on the LO->HI edge, i.e. before the chain shifts on the scan_clk rise.
  assign cap_next = (cap << 1) | B'(scan_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == S_LO) begin
        cap <= cap_next;
        if (last_bit) begin
          rb_data  <= cap_next;
          rb_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
